// File: rtl/add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/adder4_cla.sv
// Combinational 4-bit carry-lookahead slice, shared across all nibbles.
module adder4_cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign sum  = w_p ^ w_c[3:0];
    assign cout = w_c[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract done one nibble per clock through a single CLA slice,
// with valid/ready handshakes on both the operand and the result side.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | one nibble per cycle, LSB nibble first
//   DONE  | result held on outputs until out_ready
module nibble_serial_add_ctrl
    import add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = $clog2(NIB);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_c;
    logic [WIDTH-1:0]   r_result;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_sum_nib;
    logic                w_cout;
    logic                w_last;

    assign w_a_nib = r_a[NIBBLE_W*r_idx +: NIBBLE_W];
    assign w_b_nib = r_b[NIBBLE_W*r_idx +: NIBBLE_W];
    assign w_last  = (r_idx == IDX_W'(NIB - 1));

    adder4_cla u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_c),
        .sum  (w_sum_nib),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Subtraction is folded into the capture: invert B and force carry-in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= 1'b0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= in_a;
                        r_b      <= in_sub ? ~in_b : in_b;
                        r_c      <= in_sub | in_cin;
                        r_result <= '0;
                        r_idx    <= '0;
                    end
                end
                RUN: begin
                    r_result[NIBBLE_W*r_idx +: NIBBLE_W] <= w_sum_nib;
                    r_c <= w_cout;
                    if (!w_last) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_sum   = r_result;
    assign out_cout  = r_c;
    assign out_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (r_result[WIDTH-1] != r_a[WIDTH-1]);

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized and directed bench for nibble_serial_add_ctrl (WIDTH=16) against
// an arithmetic reference model with one outstanding operation.
module tb_nibble_serial_add_ctrl;

    localparam int W   = 16;
    localparam int NIB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tmo(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Reference: plain integer arithmetic, signed range check for overflow.
    function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin,
                                   output logic [W-1:0] s, output logic c, output logic v);
        int sa, sb, r, u;
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            s = a - b;
            c = (a >= b);
            r = sa - sb;
        end else begin
            u = int'(a) + int'(b) + int'(cin);
            s = u[W-1:0];
            c = u[W];
            r = sa + sb + int'(cin);
        end
        v = (r > 32767) || (r < -32768);
    endfunction

    logic         m_have = 1'b0;
    int           m_due  = 0;
    logic [W-1:0] m_sum;
    logic         m_cout;
    logic         m_ovf;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("in_ready", in_ready, !m_have);
            chk("busy", busy, m_have);
            chk("out_valid", out_valid, m_have && cyc >= m_due);
            if (m_have && cyc >= m_due) begin
                chk("out_sum", out_sum, m_sum);
                chk("out_cout", out_cout, m_cout);
                chk("out_ovf", out_ovf, m_ovf);
            end
        end
        if (rst) begin
            m_have = 1'b0;
        end else if (!m_have) begin
            if (in_valid) begin
                ref_op(in_a, in_b, in_sub, in_cin, m_sum, m_cout, m_ovf);
                m_have = 1'b1;
                m_due  = cyc + 1 + NIB;
            end
        end else if (cyc >= m_due && out_ready) begin
            m_have = 1'b0;
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
        int n;
        in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
        end
        if (n == 40) tmo("accept_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom);
        in_sub = 1'($urandom); in_cin = 1'($urandom);
    endtask

    task automatic wait_result(output int lat);
        int n;
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        if (n == 30) tmo("result_timeout");
        lat = n;
    endtask

    function automatic logic [W-1:0] pick_operand();
        unique case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        int n;
        logic [W-1:0] cap;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_sum", out_sum, 16'h0000);
        chk("reset_out_cout", out_cout, 1'b0);
        chk("reset_out_ovf", out_ovf, 1'b0);
        @(posedge clk); #1;

        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_result(lat);
        chk("latency", lat, NIB);
        chk("ffff_p1_sum", out_sum, 16'h0000);
        chk("ffff_p1_cout", out_cout, 1'b1);
        chk("ffff_p1_ovf", out_ovf, 1'b0);
        @(posedge clk); #1;

        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_result(lat);
        chk("7fff_p1_sum", out_sum, 16'h8000);
        chk("7fff_p1_cout", out_cout, 1'b0);
        chk("7fff_p1_ovf", out_ovf, 1'b1);
        @(posedge clk); #1;

        do_op(16'h0005, 16'h0007, 1'b1, 1'b0);
        wait_result(lat);
        chk("5_m_7_sum", out_sum, 16'hFFFE);
        chk("5_m_7_cout", out_cout, 1'b0);
        chk("5_m_7_ovf", out_ovf, 1'b0);
        @(posedge clk); #1;

        do_op(16'h8000, 16'h0001, 1'b1, 1'b1);
        wait_result(lat);
        chk("8000_m_1_sum", out_sum, 16'h7FFF);
        chk("8000_m_1_cout", out_cout, 1'b1);
        chk("8000_m_1_ovf", out_ovf, 1'b1);
        @(posedge clk); #1;

        // Backpressure with a competing request while the result is held.
        out_ready = 1'b0;
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_result(lat);
        cap = out_sum;
        chk("bp_first_sum", cap, 16'h3333);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = 16'h0F0F; in_b = 16'h0101; in_sub = 1'b0; in_cin = 1'b0;
            @(negedge clk);
            chk("bp_hold_sum", out_sum, cap);
            chk("bp_hold_ready", in_ready, 1'b0);
            chk("bp_hold_valid", out_valid, 1'b1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_idle_ready", in_ready, 1'b1);
        chk("bp_idle_valid", out_valid, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        wait_result(lat);
        chk("bp_second_sum", out_sum, 16'h1010);
        @(posedge clk); #1;

        // Reset during the second RUN cycle.
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", in_ready, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_valid", out_valid, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid_no_valid", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_result(lat);
        chk("after_rst_sum", out_sum, 16'h2345);
        @(posedge clk); #1;

        // Random operations with random consumer stalls.
        for (int k = 0; k < 1000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            do_op(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            for (n = 0; n < 60; n++) begin
                @(negedge clk);
                if (out_valid && out_ready) break;
                @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            if (n == 60) tmo("random_handshake_timeout");
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Multi-cycle controller that performs a WIDTH-bit add or subtract using one shared 4-bit carry-lookahead slice. It processes one nibble per clock, least-significant nibble first, and keeps the inter-nibble carry in a register. It sits between a valid/ready operand producer and a valid/ready result consumer, and trades latency for the area of a full-width adder.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 8; NIB = WIDTH/4 nibbles.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand request.
- in_ready  out  1  controller can accept; high only in IDLE.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  1 = A − B (two's complement), 0 = A + B + in_cin.
- in_cin  in  1  carry-in, used only when in_sub = 0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of MSB nibble; for subtract, 1 means no borrow.
- out_ovf  out  1  signed overflow.
- busy  out  1  high in RUN or DONE.

## Operation
States: IDLE, RUN, DONE.

IDLE:
- in_ready = 1.
- On in_valid, capture a_r = in_a, b_r = in_sub ? ~in_b : in_b, and c_r = in_sub ? 1 : in_cin.
- Clear the result register and set idx = 0, then go to RUN.

RUN, one nibble per cycle:
- The slice computes a_r[4·idx+:4] + b_r[4·idx+:4] + c_r.
- The sum nibble is written into result bits [4·idx+:4].
- c_r <= slice cout.
- idx <= idx + 1.
- On the cycle with idx == NIB−1, the final write happens and the state goes to DONE.

DONE:
- out_valid = 1.
- out_sum = result register and out_cout = c_r.
- out_ovf = (a_r[MSB] == b_r[MSB]) && (result[MSB] != a_r[MSB]), where b_r is the inverted operand when subtracting.
- Outputs stay stable until out_ready; on out_valid && out_ready, go to IDLE.

Rules:
- in_valid is ignored outside IDLE; no queuing.
- in_a, in_b, in_sub and in_cin may change freely after acceptance, because operands are registered.
- idx width is clog2(NIB); it never wraps because the RUN exit happens at NIB−1.

Reset:
- State IDLE; idx, a_r, b_r, c_r and result all 0.
- out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, busy = 0, in_ready = 1 in the cycle after reset.
- Reset asserted during RUN or DONE aborts the operation; out_valid is never raised for it.
- rst has priority over every handshake in the same cycle.

## Timing
- Acceptance edge k (in_valid && in_ready sampled high).
- RUN occupies the cycles after edges k … k+NIB−1.
- out_valid is high in the cycle after edge k+NIB, so latency is NIB cycles; with WIDTH=16 this is 4.
- in_ready and out_valid are decoded from registered state only, with no combinational path from inputs.
- Result handshake at edge m puts the block in IDLE after edge m; earliest next acceptance is edge m+1.
- Initiation interval is NIB+2 cycles with out_ready held high.
- busy = (state != IDLE).

## Structure
- Package add_ctrl_pkg contains:
  - typedef of state enum {IDLE, RUN, DONE}, 2 bits;
  - constant NIBBLE_W = 4;
  - function for nibble count from WIDTH.
- One sub-module, adder4_cla: a combinational 4-bit carry-lookahead slice with ports a[3:0], b[3:0], cin → sum[3:0], cout. It is instantiated once and driven by idx-selected nibble muxes.
- The controller holds the FSM, operand, carry and result registers, and the output decode.

## Test plan
All scenarios use WIDTH=16.
- 0xFFFF + 0x0001, cin=0 → out_sum 0x0000, out_cout 1, out_ovf 0; out_valid exactly 4 cycles after acceptance.
- 0x7FFF + 0x0001, cin=0 → out_sum 0x8000, out_cout 0, out_ovf 1.
- Subtract 0x0005 − 0x0007 → out_sum 0xFFFE, out_cout 0 (borrow), out_ovf 0; subtract 0x8000 − 0x0001 → 0x7FFF, out_ovf 1.
- Backpressure:
  - Hold out_ready low 5 cycles after out_valid, and drive a second in_valid during that time.
  - Required: outputs stay unchanged, in_ready stays 0, and the second request is taken only once back in IDLE.
- Reset mid-operation:
  - Assert rst on the 2nd RUN cycle.
  - Required: out_valid stays 0, and in_ready = 1 and busy = 0 in the cycle after reset.
  - The next operation 0x1234 + 0x1111 then yields 0x2345.
- Random:
  - 1000 operations with random operands, sub, cin and out_ready stall patterns, checked against a WIDTH+1-bit reference sum.
  - Check overflow against a signed reference.
